lsu_mem_ctrl: RTL and testbench

Load/store controller between the RISC-V core's memory stage and the word-wide data memory. It takes one byte, halfword or word load/store request at a time and turns it into word accesses on the data memory port: single reads or writes, plus read-modify-write for sub-word stores. Load data comes back sign- or zero-extended. Misaligned and out-of-window accesses are rejected without touching memory.

---
 rtl/lsu_mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: turns byte/half/word requests into word accesses on a
// registered-read data memory, with read-modify-write for sub-word stores.
module lsu_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
  parameter int unsigned DEPTH     = 16384
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [1:0]  Req_Size,
  input  logic        Req_Unsigned,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_WData,
  output logic        Resp_Valid,
  output logic        Resp_Err,
  output logic [31:0] Resp_RData,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  output logic        Mem_WE,
  input  logic [31:0] Mem_RData
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_RESP, S_ERR
  } state_t;

  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [32:0] WINDOW_BYTES = 33'(DEPTH) << 2;

  state_t      state, state_next;
  logic [31:0] off;
  logic        req_err;
  logic        accept;

  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_lane;
  logic [15:0] lat_wdata;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Request decode; offset wraps so addresses below the window look huge.
  always_comb begin
    off     = Req_Addr - BASE_ADDR;
    req_err = ({1'b0, off} >= WINDOW_BYTES)
           || (Req_Size == 2'b11)
           || (Req_Size == SZ_HALF && Req_Addr[0])
           || (Req_Size == SZ_WORD && Req_Addr[1:0] != 2'b00);
    accept  = Req_Valid && (state == S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output and next-state is defaulted first so no path can infer a latch.
  always_comb begin
    state_next = state;
    Req_Ready  = 1'b0;
    Resp_Valid = 1'b0;
    Resp_Err   = 1'b0;
    Mem_WE     = 1'b0;
    unique case (state)
      S_IDLE: begin
        Req_Ready = 1'b1;
        if (Req_Valid) begin
          if (req_err)                             state_next = S_ERR;
          else if (Req_Write && Req_Size == SZ_WORD) state_next = S_WRITE;
          else                                     state_next = S_READ;
        end
      end
      S_READ:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = lat_write ? S_WRITE : S_RESP;
      // NOTE: Mem_WE is decoded from state, so an async reset drops it before the next edge.
      S_WRITE: begin
        Mem_WE     = 1'b1;
        state_next = S_RESP;
      end
      S_RESP: begin
        Resp_Valid = 1'b1;
        state_next = S_IDLE;
      end
      S_ERR: begin
        Resp_Valid = 1'b1;
        Resp_Err   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_sel   = Mem_RData[{lat_lane, 3'b000} +: 8];
    half_sel   = lat_lane[1] ? Mem_RData[31:16] : Mem_RData[15:0];
    load_data  = Mem_RData;
    merge_data = Mem_RData;
    if (lat_size == SZ_BYTE) begin
      load_data = {{24{~lat_unsigned & byte_sel[7]}}, byte_sel};
      merge_data[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
    end else if (lat_size == SZ_HALF) begin
      load_data = {{16{~lat_unsigned & half_sel[15]}}, half_sel};
      merge_data[{lat_lane[1], 4'b0000} +: 16] = lat_wdata;
    end
  end

  // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lat_write    <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_lane     <= 2'b00;
      lat_wdata    <= '0;
      Resp_RData   <= '0;
      Mem_Addr     <= '0;
      Mem_WData    <= '0;
    end else begin
      if (accept) begin
        lat_write    <= Req_Write;
        lat_size     <= Req_Size;
        lat_unsigned <= Req_Unsigned;
        lat_lane     <= Req_Addr[1:0];
        lat_wdata    <= Req_WData[15:0];
        Resp_RData   <= '0;
        if (!req_err) begin
          Mem_Addr <= BASE_ADDR + {2'b00, off[31:2]};
          if (Req_Write && Req_Size == SZ_WORD) Mem_WData <= Req_WData;
        end
      end
      if (state == S_CAPTURE) begin
        if (lat_write) Mem_WData  <= merge_data;
        else           Resp_RData <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a registered-read word memory model.
module tb_lsu_mem_ctrl;

  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic        CLK;
  logic        RST_N;
  logic        Req_Valid, Req_Ready, Req_Write, Req_Unsigned;
  logic [1:0]  Req_Size;
  logic [31:0] Req_Addr, Req_WData;
  logic        Resp_Valid, Resp_Err;
  logic [31:0] Resp_RData, Mem_Addr, Mem_WData, Mem_RData;
  logic        Mem_WE;

  lsu_mem_ctrl #(.BASE_ADDR(BASE), .DEPTH(16384)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
    .Req_Size(Req_Size), .Req_Unsigned(Req_Unsigned), .Req_Addr(Req_Addr),
    .Req_WData(Req_WData), .Resp_Valid(Resp_Valid), .Resp_Err(Resp_Err),
    .Resp_RData(Resp_RData), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_WE(Mem_WE), .Mem_RData(Mem_RData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Word memory aliased on the low 8 bits of the word index.
  logic [31:0] mem [256];
  logic [31:0] mem_off;
  logic [7:0]  midx;
  assign mem_off = Mem_Addr - BASE;
  assign midx    = mem_off[7:0];
  always @(posedge CLK) begin
    if (Mem_WE) mem[midx] <= Mem_WData;
    else        Mem_RData <= mem[midx];
  end

  int checks   = 0;
  int failures = 0;

  int          resp_cyc, we_cyc, we_cnt;
  logic        r_err;
  logic [31:0] r_data, we_addr, we_data, c1_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and watch cycles 1..6 after the accept edge.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    Req_Valid = 1'b1; Req_Write = w; Req_Size = sz; Req_Unsigned = u;
    Req_Addr = a; Req_WData = d;
    @(posedge CLK); #1;
    Req_Valid = 1'b0;
    resp_cyc = 0; we_cyc = 0; we_cnt = 0;
    r_err = 1'bx; r_data = 'x; we_addr = 'x; we_data = 'x;
    c1_addr = Mem_Addr;
    for (int c = 1; c <= 6; c++) begin
      if (Resp_Valid && resp_cyc == 0) begin
        resp_cyc = c; r_err = Resp_Err; r_data = Resp_RData;
      end
      if (Mem_WE) begin
        we_cnt++;
        if (we_cyc == 0) begin
          we_cyc = c; we_addr = Mem_Addr; we_data = Mem_WData;
        end
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic expect_err(input string tag);
    check({tag, "_resp_cyc"}, 32'(resp_cyc), 32'd1);
    check({tag, "_err"},      {31'd0, r_err}, 32'd1);
    check({tag, "_rdata"},    r_data, 32'h0);
    check({tag, "_we_cnt"},   32'(we_cnt), 32'd0);
  endtask

  int          r1c, r2c;
  logic [31:0] d1, d2;
  logic [7:0]  rdy_bits;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; Req_Valid = 1'b0; Req_Write = 1'b0; Req_Size = 2'b00;
    Req_Unsigned = 1'b0; Req_Addr = '0; Req_WData = '0;
    repeat (3) @(posedge CLK); #1;
    check("rst_ready",      {31'd0, Req_Ready},  32'd1);
    check("rst_resp_valid", {31'd0, Resp_Valid}, 32'd0);
    check("rst_resp_err",   {31'd0, Resp_Err},   32'd0);
    check("rst_mem_we",     {31'd0, Mem_WE},     32'd0);
    check("rst_rdata",      Resp_RData, 32'h0);
    check("rst_mem_addr",   Mem_Addr,   32'h0);
    check("rst_mem_wdata",  Mem_WData,  32'h0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Preload word index 0x10 through a word store.
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF0040, 32'h8899AABB);
    check("pre_resp_cyc", 32'(resp_cyc), 32'd2);

    do_req(1'b0, 2'b00, 1'b0, 32'hFFFF0041, 32'h0);
    check("lb_c1_addr",  c1_addr, 32'hFFFF0010);
    check("lb_resp_cyc", 32'(resp_cyc), 32'd3);
    check("lb_err",      {31'd0, r_err}, 32'd0);
    check("lb_data",     r_data, 32'hFFFFFFAA);
    check("lb_we_cnt",   32'(we_cnt), 32'd0);

    do_req(1'b0, 2'b00, 1'b1, 32'hFFFF0041, 32'h0);
    check("lbu_data", r_data, 32'h000000AA);
    do_req(1'b0, 2'b01, 1'b0, 32'hFFFF0042, 32'h0);
    check("lh_data", r_data, 32'hFFFF8899);
    do_req(1'b0, 2'b01, 1'b1, 32'hFFFF0042, 32'h0);
    check("lhu_data", r_data, 32'h00008899);
    do_req(1'b0, 2'b00, 1'b0, 32'hFFFF0040, 32'h0);
    check("lb0_data", r_data, 32'hFFFFFFBB);

    do_req(1'b1, 2'b00, 1'b0, 32'hFFFF0043, 32'h12345655);
    check("sb_c1_addr",  c1_addr, 32'hFFFF0010);
    check("sb_we_cyc",   32'(we_cyc), 32'd3);
    check("sb_we_cnt",   32'(we_cnt), 32'd1);
    check("sb_we_addr",  we_addr, 32'hFFFF0010);
    check("sb_we_data",  we_data, 32'h5599AABB);
    check("sb_resp_cyc", 32'(resp_cyc), 32'd4);
    check("sb_err",      {31'd0, r_err}, 32'd0);
    check("sb_rdata",    r_data, 32'h0);

    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF0008, 32'hDEADBEEF);
    check("sw_we_cyc",   32'(we_cyc), 32'd1);
    check("sw_we_cnt",   32'(we_cnt), 32'd1);
    check("sw_we_addr",  we_addr, 32'hFFFF0002);
    check("sw_we_data",  we_data, 32'hDEADBEEF);
    check("sw_resp_cyc", 32'(resp_cyc), 32'd2);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF0008, 32'h0);
    check("lw_data",     r_data, 32'hDEADBEEF);
    check("lw_resp_cyc", 32'(resp_cyc), 32'd3);

    // Last word of the window, then halfword store into its upper half.
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'hCAFEF00D);
    check("top_sw_we_addr", we_addr, 32'hFFFF3FFF);
    do_req(1'b1, 2'b01, 1'b0, 32'hFFFFFFFE, 32'h00001234);
    check("top_sh_we_data", we_data, 32'h1234F00D);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0);
    check("top_lw_err",  {31'd0, r_err}, 32'd0);
    check("top_lw_data", r_data, 32'h1234F00D);

    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF0042, 32'h0);
    expect_err("err_lw_mis");
    do_req(1'b1, 2'b01, 1'b0, 32'hFFFF0001, 32'hFFFFFFFF);
    expect_err("err_sh_mis");
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFEFFFC, 32'h0);
    expect_err("err_below");
    do_req(1'b0, 2'b11, 1'b0, 32'hFFFF0040, 32'h0);
    expect_err("err_size3");

    // Reset during CAPTURE of a byte store.
    Req_Valid = 1'b1; Req_Write = 1'b1; Req_Size = 2'b00; Req_Unsigned = 1'b0;
    Req_Addr = 32'hFFFF0040; Req_WData = 32'h00000077;
    @(posedge CLK); #1;
    Req_Valid = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b0; #1;
    check("rcap_we",         {31'd0, Mem_WE},     32'd0);
    check("rcap_resp_valid", {31'd0, Resp_Valid}, 32'd0);
    check("rcap_ready",      {31'd0, Req_Ready},  32'd1);
    check("rcap_mem_addr",   Mem_Addr,   32'h0);
    check("rcap_mem_wdata",  Mem_WData,  32'h0);
    check("rcap_rdata",      Resp_RData, 32'h0);
    repeat (2) @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF0040, 32'h0);
    check("rcap_reread", r_data, 32'h5599AABB);

    // Reset during WRITE of a word store.
    Req_Valid = 1'b1; Req_Write = 1'b1; Req_Size = 2'b10;
    Req_Addr = 32'hFFFF0008; Req_WData = 32'h11111111;
    @(posedge CLK); #1;
    Req_Valid = 1'b0;
    check("rwr_we_before", {31'd0, Mem_WE}, 32'd1);
    #2 RST_N = 1'b0;
    #1;
    check("rwr_we_after", {31'd0, Mem_WE}, 32'd0);
    repeat (2) @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF0008, 32'h0);
    check("rwr_reread", r_data, 32'hDEADBEEF);

    // Back-to-back loads with Req_Valid held high.
    Req_Valid = 1'b1; Req_Write = 1'b0; Req_Size = 2'b10; Req_Unsigned = 1'b0;
    Req_Addr = 32'hFFFF0008;
    r1c = 0; r2c = 0; d1 = 'x; d2 = 'x; rdy_bits = '0;
    @(posedge CLK); #1;
    for (int c = 1; c <= 8; c++) begin
      rdy_bits[c-1] = Req_Ready;
      if (Resp_Valid) begin
        if (r1c == 0)      begin r1c = c; d1 = Resp_RData; end
        else if (r2c == 0) begin r2c = c; d2 = Resp_RData; end
      end
      if (c == 4) Req_Addr = 32'hFFFF0040;
      if (c == 5) Req_Valid = 1'b0;
      @(posedge CLK); #1;
    end
    check("b2b_resp1_cyc", 32'(r1c), 32'd3);
    check("b2b_resp2_cyc", 32'(r2c), 32'd7);
    check("b2b_data1",     d1, 32'hDEADBEEF);
    check("b2b_data2",     d2, 32'h5599AABB);
    check("b2b_ready",     {24'd0, rdy_bits}, 32'h00000088);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
